intadd_wb: RTL
==============

Name: intadd_wb

Overview:
- Writeback stage directly downstream of the intadd integer-add unit.
- Captures each valid intadd result set: dst_reg0, dst_reg1 and the 128-bit st status vector.
- Buffers the results in a small FIFO and serialises them onto a single 128-bit register-file write port with ready backpressure.
- Keeps an architectural sticky status register, OR-accumulated from st whenever update_st was set.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- AW, 5, register-file address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  intadd result valid; this is the inst_valid bit of cru_intadd, delayed to align with the results.
- in_ready  out  1  stage can accept a result.
- in_dst0  in  128  intadd dst_reg0.
- in_dst1  in  128  intadd dst_reg1.
- in_st  in  128  intadd st.
- in_update_st  in  1  update_st bit of the issuing microinstruction.
- in_dual  in  1  result has two destinations (8/4-bit three-source mode, precision 00); 0 means dst0 only (32-bit mode).
- in_addr0  in  AW  destination register for dst0.
- in_addr1  in  AW  destination register for dst1; ignored when in_dual=0.
- rf_we  out  1  register-file write request.
- rf_waddr  out  AW  write address.
- rf_wdata  out  128  write data.
- rf_ready  in  1  register file accepts the write this cycle.
- st_clr  in  1  clear sticky status.
- st_sticky  out  128  accumulated status.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied; pending entries discarded.
  - FSM set to IDLE; st_sticky=0.
  - Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0.
  - in_ready=0 while rst is high, 1 on the first cycle after.
  - Reset mid-write: the write is abandoned; rf_we is 0 in the cycle after the reset edge.
- Push:
  - Accept when in_valid & in_ready.
  - Entry fields: {dst0, dst1, st, update_st, dual, addr0, addr1}.
  - in_ready = !full. A pop in the same cycle does not enable a push when full.
  - in_valid while in_ready=0: data is dropped. This is a protocol violation upstream; the RTL need not flag it.
- Drain FSM (outputs driven from the FIFO head, gated by state):
  - IDLE: rf_we=0. If the FIFO is non-empty, go to WR0.
  - WR0: rf_we=1, rf_waddr=head.addr0, rf_wdata=head.dst0.
    - On rf_ready with head.dual=1: go to WR1.
    - On rf_ready with head.dual=0: pop; go to WR0 if entries remain, else IDLE.
  - WR1: rf_we=1, rf_waddr=head.addr1, rf_wdata=head.dst1.
    - On rf_ready: pop; go to WR0 if entries remain, else IDLE.
  - rf_ready=0: stay in the current state; rf_waddr and rf_wdata stay stable.
- Latency and throughput:
  - Accept at edge k gives rf_we=1 in the cycle following edge k+1 (2-cycle minimum).
  - Back-to-back single-destination results sustain 1 write/cycle with rf_ready held high.
  - Dual-destination results take 2 write cycles each.
- Sticky status:
  - Updated only at pop, i.e. after the entry's last write: if head.update_st, st_sticky <= st_sticky | head.st.
  - st_clr alone: st_sticky <= 0.
  - st_clr in the same cycle as a pop with update_st: st_sticky <= head.st (clear, then set).
  - Entries with update_st=0 never modify st_sticky.
- FIFO pointers: log2(DEPTH) bits, wrap naturally, plus a count register for full/empty.
  - Simultaneous push and pop when not full: count unchanged.
- busy = (count != 0) | (state != IDLE).

Optional Feature:
- Macro: INTADD_WB_PERF_EN.
- When defined, adds two 32-bit outputs, both cleared on rst and wrapping at 2^32:
  - perf_wr_cnt: increments on every rf_we & rf_ready.
  - perf_stall_cnt: increments on every cycle with rf_we & !rf_ready.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single 32-bit result, rf_ready=1: in_dst0=0x80000000_x4, addr0=3, dual=0, update_st=1, st=0x1_x4 -> one write to addr 3 two cycles after accept; st_sticky=0x00000001_x4 after pop; busy then 0.
- Dual result, rf_ready=1: addr0=5, addr1=6, dual=1 -> consecutive writes (5,dst0) then (6,dst1); pop after second; update_st=0 leaves st_sticky unchanged.
- Backpressure: 5 dual results pushed with rf_ready=0 -> in_ready=0 after 4 accepts; rf_waddr/wdata stable while stalled; releasing rf_ready drains 8 writes in order with no loss.
- Sticky accumulate and clear: pops with st=0x...01, then 0x...10 (update_st=1) -> 0x...11; st_clr asserted in the same cycle as a pop with st=0x...04 -> 0x...04.
- Reset mid-operation: rst during WR1 with 3 entries queued -> rf_we=0 next cycle, busy=0, st_sticky=0; a fresh push is written normally.
- Perf (macro on): 3 stall cycles then 2 writes -> perf_stall_cnt=3, perf_wr_cnt=2.

Source files
------------

// File: rtl/intadd_wb_if.sv
// intadd_wb_if: intadd result capture and register-file write port bundle.
// slave = writeback stage, master = upstream/regfile side.
interface intadd_wb_if #(
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_dst0;
  logic [127:0]  in_dst1;
  logic [127:0]  in_st;
  logic          in_update_st;
  logic          in_dual;
  logic [AW-1:0] in_addr0;
  logic [AW-1:0] in_addr1;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [127:0]  rf_wdata;
  logic          rf_ready;

  modport slave (
    input  in_valid, in_dst0, in_dst1, in_st,
    input  in_update_st, in_dual, in_addr0, in_addr1,
    output in_ready,
    output rf_we, rf_waddr, rf_wdata,
    input  rf_ready
  );

  modport master (
    output in_valid, in_dst0, in_dst1, in_st,
    output in_update_st, in_dual, in_addr0, in_addr1,
    input  in_ready,
    input  rf_we, rf_waddr, rf_wdata,
    output rf_ready
  );
endinterface

// File: rtl/intadd_wb.sv
// intadd_wb: intadd writeback stage, FIFO + regfile write serialiser.
// INTADD_WB_PERF_EN adds perf_wr_cnt / perf_stall_cnt counters.
module intadd_wb #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic         clk,
  input  logic         rst,
  intadd_wb_if.slave   bus,
  input  logic         st_clr,
  output logic [127:0] st_sticky,
  output logic         busy
`ifdef INTADD_WB_PERF_EN
  ,
  output logic [31:0]  perf_wr_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [127:0]  dst0;
    logic [127:0]  dst1;
    logic [127:0]  st;
    logic          update_st;
    logic          dual;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WR0,
    WR1
  } state_t;

  state_t        state, state_nx;
  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        wr_entry;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty;
  logic          push, pop;
  logic          remain;

  assign head  = mem[rd_ptr];
  assign full  = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign busy  = !empty || state != IDLE;

  assign bus.in_ready = !rst && !full;
  assign push = bus.in_valid && bus.in_ready;

  // After this pop, does anything remain (a same-cycle push counts)?
  assign remain = count > (PW+1)'(1) || push;

  assign wr_entry = '{
    dst0:      bus.in_dst0,
    dst1:      bus.in_dst1,
    st:        bus.in_st,
    update_st: bus.in_update_st,
    dual:      bus.in_dual,
    addr0:     bus.in_addr0,
    addr1:     bus.in_addr1
  };

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    pop          = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    unique case (state)
      IDLE: begin
        if (!empty) state_nx = WR0;
      end
      WR0: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = head.addr0;
        bus.rf_wdata = head.dst0;
        if (bus.rf_ready) begin
          if (head.dual) begin
            state_nx = WR1;
          end else begin
            pop      = 1'b1;
            state_nx = remain ? WR0 : IDLE;
          end
        end
      end
      WR1: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = head.addr1;
        bus.rf_wdata = head.dst1;
        if (bus.rf_ready) begin
          pop      = 1'b1;
          state_nx = remain ? WR0 : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Clear takes effect before the popped entry's status is merged.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_sticky <= '0;
    end else if (pop && head.update_st) begin
      st_sticky <= (st_clr ? '0 : st_sticky) | head.st;
    end else if (st_clr) begin
      st_sticky <= '0;
    end
  end

`ifdef INTADD_WB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (bus.rf_we && bus.rf_ready)
        perf_wr_cnt <= perf_wr_cnt + 32'd1;
      if (bus.rf_we && !bus.rf_ready)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
